// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes used by the ALU and the ALU decoder,
// plus the shifter mode type.
package alu_pkg;

   localparam int ALU_CTRL_W = 4;
   localparam int SHAMT_W    = 5;

   localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0010;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0110;
   localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b1110;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0001;
   localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0011;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b0100;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b0101;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b1101;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b0111;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b1111;

   typedef enum logic [1:0] {
      SH_LEFT        = 2'd0,
      SH_RIGHT_LOG   = 2'd1,
      SH_RIGHT_ARITH = 2'd2
   } shift_mode_e;

endpackage : alu_pkg

// File: rtl/alu_shifter.sv
// Barrel shifter for the ALU: left, logical right and arithmetic right shifts
// by a 5-bit amount.
module alu_shifter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [SHAMT_W-1:0] shamt,
   input  shift_mode_e        mode,
   output logic [WIDTH-1:0]   y
);

   logic signed [WIDTH-1:0] a_s;

   assign a_s = a;

   // Select the shift direction and fill according to mode.
   always_comb begin
      y = '0;
      case (mode)
         SH_LEFT:        y = a << shamt;
         SH_RIGHT_LOG:   y = a >> shamt;
         SH_RIGHT_ARITH: y = a_s >>> shamt;
         default:        y = '0;
      endcase
   end

endmodule : alu_shifter

// File: rtl/alu_unit.sv
// Combinational RV32I ALU with a Zero flag and a registered debug/trace copy
// of the result and flag.
module alu_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WIDTH-1:0]      A,
   input  logic [WIDTH-1:0]      B,
   input  logic [ALU_CTRL_W-1:0] alu_control,
   output logic [WIDTH-1:0]      alu_out,
   output logic                  Zero,
   output logic [WIDTH-1:0]      alu_out_q,
   output logic                  zero_q
);

   logic signed [WIDTH-1:0] a_s;
   logic signed [WIDTH-1:0] b_s;
   logic                    lt_signed;
   logic                    lt_unsigned;
   shift_mode_e             sh_mode;
   logic [WIDTH-1:0]        sh_y;
   logic [WIDTH-1:0]        alu_out_d;
   logic                    zero_d;

   // Direct signed compare so SLT is correct across the sign boundary
   // (the sign of A - B alone is wrong when the subtraction overflows).
   assign a_s         = A;
   assign b_s         = B;
   assign lt_signed   = (a_s < b_s);
   assign lt_unsigned = (A < B);

   // Pick the shifter mode from the operation code.
   always_comb begin
      sh_mode = SH_RIGHT_LOG;
      case (alu_control)
         ALU_SLL: sh_mode = SH_LEFT;
         ALU_SRA: sh_mode = SH_RIGHT_ARITH;
         default: sh_mode = SH_RIGHT_LOG;
      endcase
   end

   alu_shifter #(
      .WIDTH (WIDTH)
   ) u_shifter (
      .a     (A),
      .shamt (B[SHAMT_W-1:0]),
      .mode  (sh_mode),
      .y     (sh_y)
   );

   // Operation select; unused codes yield zero so Zero reads 1.
   always_comb begin
      alu_out = '0;
      case (alu_control)
         ALU_ADD:  alu_out = A + B;
         ALU_SUB:  alu_out = A - B;
         ALU_AND:  alu_out = A & B;
         ALU_OR:   alu_out = A | B;
         ALU_XOR:  alu_out = A ^ B;
         ALU_SLL:  alu_out = sh_y;
         ALU_SRL:  alu_out = sh_y;
         ALU_SRA:  alu_out = sh_y;
         ALU_SLT:  alu_out = {{(WIDTH-1){1'b0}}, lt_signed};
         ALU_SLTU: alu_out = {{(WIDTH-1){1'b0}}, lt_unsigned};
         default:  alu_out = '0;
      endcase
   end

   assign Zero = (alu_out == '0);

   // Next values for the debug copies are the current combinational outputs.
   always_comb begin
      alu_out_d = alu_out;
      zero_d    = Zero;
   end

   // Debug/trace register stage with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_out_q <= '0;
         zero_q    <= 1'b0;
      end else begin
         alu_out_q <= alu_out_d;
         zero_q    <= zero_d;
      end
   end

endmodule : alu_unit

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: stimulus pushes expected responses, a monitor
// pops and compares them against the combinational or registered outputs.
module tb_alu_unit;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] A;
   logic [31:0] B;
   logic [3:0]  alu_control;
   logic [31:0] alu_out;
   logic        Zero;
   logic [31:0] alu_out_q;
   logic        zero_q;

   typedef struct {
      bit          reg_chk;
      string       name;
      logic [31:0] v;
      logic        z;
   } exp_t;

   exp_t exp_q[$];
   event sample_ev;
   int   compared   = 0;
   int   mismatched = 0;

   alu_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .A           (A),
      .B           (B),
      .alu_control (alu_control),
      .alu_out     (alu_out),
      .Zero        (Zero),
      .alu_out_q   (alu_out_q),
      .zero_q      (zero_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: the DUT output is presented when stimulus signals it.
   initial begin
      exp_t e;
      logic [31:0] got_v;
      logic        got_z;
      forever begin
         @(sample_ev);
         while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.reg_chk) begin
               got_v = alu_out_q;
               got_z = zero_q;
            end else begin
               got_v = alu_out;
               got_z = Zero;
            end
            compared++;
            if (got_v !== e.v || got_z !== e.z) begin
               mismatched++;
               $display("FAIL %s: got out=%h zero=%b, want out=%h zero=%b",
                        e.name, got_v, got_z, e.v, e.z);
            end
         end
      end
   end

   task automatic expect_out(input bit reg_chk, input string name,
                             input logic [31:0] v, input logic z);
      exp_t e;
      e.reg_chk = reg_chk;
      e.name    = name;
      e.v       = v;
      e.z       = z;
      exp_q.push_back(e);
      ->sample_ev;
      #0;
   endtask

   task automatic apply(input logic [3:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] v,
                        input logic z, input string name);
      alu_control = ctrl;
      A = a;
      B = b;
      #1;
      expect_out(1'b0, name, v, z);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n       = 1'b0;
      A           = 32'd0;
      B           = 32'd0;
      alu_control = 4'b0000;

      // Reset held: registered outputs stay clear across edges while inputs toggle.
      #2;
      expect_out(1'b1, "rst_hold_0", 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         alu_control = ALU_ADD;
         A = 32'd5 + i;
         B = 32'd3;
         @(posedge clk);
         #1;
         expect_out(1'b1, "rst_hold_edge", 32'h0, 1'b0);
         expect_out(1'b0, "rst_comb_live", 32'd8 + i, 1'b0);
      end

      // Release reset away from the edge, then capture ADD 5+3.
      @(negedge clk);
      rst_n = 1'b1;
      alu_control = ALU_ADD;
      A = 32'd5;
      B = 32'd3;
      #1;
      expect_out(1'b1, "post_release_no_edge", 32'h0, 1'b0);
      @(posedge clk);
      #1;
      expect_out(1'b1, "reg_add", 32'h8, 1'b0);

      // A zero result is captured with zero_q set.
      alu_control = ALU_SUB;
      A = 32'd3;
      B = 32'd3;
      @(posedge clk);
      #1;
      expect_out(1'b1, "reg_sub_zero", 32'h0, 1'b1);

      // Inputs changed exactly at the edge: register takes the pre-edge value.
      alu_control = ALU_ADD;
      A = 32'd5;
      B = 32'd3;
      @(posedge clk);
      A = 32'd100;
      #1;
      expect_out(1'b1, "reg_pre_edge", 32'h8, 1'b0);
      expect_out(1'b0, "comb_post_edge", 32'd103, 1'b0);

      // Mid-cycle asynchronous reset clears immediately.
      #2;
      rst_n = 1'b0;
      #1;
      expect_out(1'b1, "async_clear", 32'h0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Combinational vectors.
      apply(ALU_ADD,  32'd5,        32'd3,        32'h00000008, 1'b0, "add_5_3");
      apply(ALU_SUB,  32'd5,        32'd3,        32'h00000002, 1'b0, "sub_5_3");
      apply(ALU_SUB,  32'd3,        32'd3,        32'h00000000, 1'b1, "sub_3_3");
      apply(ALU_SUB,  32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, "sub_3_5");
      apply(ALU_AND,  32'hF,        32'h3,        32'h00000003, 1'b0, "and");
      apply(ALU_ADD,  32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b1, "add_wrap");
      apply(ALU_ADD,  32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, "add_ovf");
      apply(ALU_OR,   32'hC,        32'h3,        32'h0000000F, 1'b0, "or");
      apply(ALU_XOR,  32'hF,        32'h3,        32'h0000000C, 1'b0, "xor");
      apply(ALU_SLL,  32'd1,        32'd4,        32'h00000010, 1'b0, "sll_4");
      apply(ALU_SLL,  32'd1,        32'd31,       32'h80000000, 1'b0, "sll_31");
      apply(ALU_SLL,  32'd1,        32'h21,       32'h00000002, 1'b0, "sll_b_hi_ignored");
      apply(ALU_SRL,  32'h10,       32'd2,        32'h00000004, 1'b0, "srl_2");
      apply(ALU_SRL,  32'h80000000, 32'd4,        32'h08000000, 1'b0, "srl_neg");
      apply(ALU_SRA,  32'h80000000, 32'd4,        32'hF8000000, 1'b0, "sra_neg");
      apply(ALU_SRA,  32'h40000000, 32'd4,        32'h04000000, 1'b0, "sra_pos");
      apply(ALU_SRA,  32'h80000000, 32'h20,       32'h80000000, 1'b0, "sra_shamt0");
      apply(ALU_SLT,  32'd2,        32'd5,        32'h00000001, 1'b0, "slt_2_5");
      apply(ALU_SLT,  32'h80000000, 32'd1,        32'h00000001, 1'b0, "slt_signbound");
      apply(ALU_SLT,  32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, "slt_maxpos_minneg");
      apply(ALU_SLTU, 32'h80000000, 32'd1,        32'h00000000, 1'b1, "sltu_big_1");
      apply(ALU_SLTU, 32'd1,        32'h80000000, 32'h00000001, 1'b0, "sltu_1_big");
      apply(ALU_SLT,  32'd5,        32'd5,        32'h00000000, 1'b1, "slt_eq");
      apply(4'b0000,  32'd7,        32'd9,        32'h00000000, 1'b1, "unused_0000");
      apply(4'b1000,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, "unused_1000");

      // Drain the scoreboard within a bounded time.
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) #1;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_alu_unit
